// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: ALU operation codes, branch funct3 values
// and forwarding-mux select codes.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // 2'b11 is unused and falls back to the register-file operand.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Purely combinational RV32I ALU: ADD/SUB/AND/OR/XOR/SLT, undefined ops yield 0.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution toward fetch,
// and the execute/memory pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  BranchE,
    input  logic                  JumpE,
    input  logic [2:0]            Funct3E,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1E,
    input  logic [XLEN-1:0]       RD2E,
    input  logic [XLEN-1:0]       ImmExtE,
    input  logic [REG_ADDR_W-1:0] RDE,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [REG_ADDR_W-1:0] RDM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] FwdBE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] ALUResultE;
    logic            ZeroE;
    logic            BranchCondE;

    // ALUResultM is a register output, so the MEM forward path never loops
    // combinationally through the ALU.
    always_comb begin
        SrcAE = RD1E;
        case (ForwardAE)
            FWD_WB:  SrcAE = ResultW;
            FWD_MEM: SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
    end

    always_comb begin
        FwdBE = RD2E;
        case (ForwardBE)
            FWD_WB:  FwdBE = ResultW;
            FWD_MEM: FwdBE = ALUResultM;
            default: FwdBE = RD2E;
        endcase
    end

    assign SrcBE = ALUSrcE ? ImmExtE : FwdBE;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (SrcAE),
        .SrcB       (SrcBE),
        .ALUControl (ALUControlE),
        .Result     (ALUResultE),
        .Zero       (ZeroE)
    );

    // Branches compare the register operands, never the immediate.
    always_comb begin
        BranchCondE = 1'b0;
        case (Funct3E)
            F3_BEQ:  BranchCondE = (SrcAE == FwdBE);
            F3_BNE:  BranchCondE = (SrcAE != FwdBE);
            F3_BLT:  BranchCondE = ($signed(SrcAE) <  $signed(FwdBE));
            F3_BGE:  BranchCondE = ($signed(SrcAE) >= $signed(FwdBE));
            default: BranchCondE = 1'b0;
        endcase
    end

    assign PCSrcE    = (BranchE & BranchCondE) | JumpE;
    assign PCTargetE = PCE + ImmExtE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RDM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RDM        <= RDE;
            ALUResultM <= ZeroE ? '0 : ALUResultE;
            WriteDataM <= FwdBE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed plan steps plus randomized cycles checked
// against an arithmetic reference model of the execute stage.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  Funct3E, ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RDE;
    logic        PCSrcE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RDM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        regw;
        logic        memw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } mreg_t;

    mreg_t exp_q[$];
    mreg_t cur;

    localparam longint unsigned MOD = 64'h1_0000_0000;

    execute_cycle #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .Funct3E(Funct3E), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RDE(RDE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
        return 32'((longint'(a) + longint'(b)) % MOD);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return add_ref(a, b);
            3'd1: return 32'((longint'(a) + MOD - longint'(b)) % MOD);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return cur.alu;
        return reg_val;
    endfunction

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
        ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; Funct3E = 0; ALUControlE = 0;
        RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RDE = 0;
    endtask

    task automatic randomize_inputs();
        RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
        BranchE = 1'($urandom); JumpE = ($urandom_range(0, 3) == 0);
        ResultSrcE = 2'($urandom_range(0, 3));
        ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
        Funct3E = 3'($urandom_range(0, 7)); ALUControlE = 3'($urandom_range(0, 7));
        RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        ImmExtE = $urandom; PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
        RDE = 5'($urandom_range(0, 31));
    endtask

    // Checks the combinational redirect, clocks once, then checks the M register.
    task automatic step(input bit do_comb);
        logic [31:0] a, fb, b;
        mreg_t nx;
        #1;
        a  = fwd_ref(ForwardAE, RD1E);
        fb = fwd_ref(ForwardBE, RD2E);
        b  = ALUSrcE ? ImmExtE : fb;
        if (do_comb) begin
            chk("pcsrc", {31'd0, PCSrcE}, {31'd0, (BranchE && br_ref(Funct3E, a, fb)) || JumpE});
            chk("pctarget", PCTargetE, add_ref(PCE, ImmExtE));
        end
        if (!rst) nx = '{regw: 0, memw: 0, rs: 0, rd: 0, alu: 0, wd: 0, pc4: 0};
        else nx = '{regw: RegWriteE, memw: MemWriteE, rs: ResultSrcE, rd: RDE,
                    alu: alu_ref(ALUControlE, a, b), wd: fb, pc4: PCPlus4E};
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        cur = exp_q.pop_front();
        chk("regwrite_m", {31'd0, RegWriteM}, {31'd0, cur.regw});
        chk("memwrite_m", {31'd0, MemWriteM}, {31'd0, cur.memw});
        chk("resultsrc_m", {30'd0, ResultSrcM}, {30'd0, cur.rs});
        chk("rd_m", {27'd0, RDM}, {27'd0, cur.rd});
        chk("aluresult_m", ALUResultM, cur.alu);
        chk("writedata_m", WriteDataM, cur.wd);
        chk("pcplus4_m", PCPlus4M, cur.pc4);
    endtask

    initial begin
        cur = '{regw: 0, memw: 0, rs: 0, rd: 0, alu: 0, wd: 0, pc4: 0};
        clear_inputs();

        // Reset with random inputs for two edges; register contents unknown before the first.
        rst = 0;
        randomize_inputs();
        step(0);
        randomize_inputs();
        step(1);
        chk("reset_alu", ALUResultM, 32'd0);
        chk("reset_pc4", PCPlus4M, 32'd0);

        // First edge after release captures live inputs.
        rst = 1;
        clear_inputs();
        RD1E = 5; RD2E = 7;
        step(1);
        chk("release_add", ALUResultM, 32'd12);

        // BEQ taken / not taken, target wraps with negative immediate.
        clear_inputs();
        BranchE = 1; Funct3E = 3'b000; RD1E = 32'h10; RD2E = 32'h10;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
        chk("beq_target", PCTargetE, 32'hF8);
        step(1);
        RD2E = 32'h11;
        #1;
        chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
        step(1);

        // Signed BLT/BGE and unconditional jump.
        clear_inputs();
        BranchE = 1; Funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
        #1;
        chk("blt_signed", {31'd0, PCSrcE}, 32'd1);
        step(1);
        Funct3E = 3'b101;
        #1;
        chk("bge_signed", {31'd0, PCSrcE}, 32'd0);
        step(1);
        BranchE = 0; JumpE = 1;
        #1;
        chk("jump", {31'd0, PCSrcE}, 32'd1);
        step(1);

        // Back-to-back forwarding from ALUResultM, then WB forwarding into store data.
        clear_inputs();
        RD1E = 3; RD2E = 4;
        step(1);
        chk("fwd_base", ALUResultM, 32'd7);
        clear_inputs();
        ForwardAE = 2'b10; ImmExtE = 1; ALUSrcE = 1;
        step(1);
        chk("fwd_mem", ALUResultM, 32'd8);
        clear_inputs();
        ForwardBE = 2'b01; ResultW = 32'h20; MemWriteE = 1;
        step(1);
        chk("fwd_wb_store", WriteDataM, 32'h20);
        chk("fwd_wb_memw", {31'd0, MemWriteM}, 32'd1);

        // ALU operation corners.
        clear_inputs();
        ALUControlE = 3'b001; RD1E = 0; RD2E = 1;
        step(1);
        chk("sub_wrap", ALUResultM, 32'hFFFF_FFFF);
        ALUControlE = 3'b101; RD1E = 32'h8000_0000; RD2E = 0;
        step(1);
        chk("slt_neg", ALUResultM, 32'd1);
        ALUControlE = 3'b100; RD1E = 32'hF0F0; RD2E = 32'hFF00;
        step(1);
        chk("xor", ALUResultM, 32'h0FF0);
        ALUControlE = 3'b111; RD1E = 32'h1234; RD2E = 32'h5678;
        step(1);
        chk("op111", ALUResultM, 32'd0);

        // Passthrough, held for two edges.
        clear_inputs();
        RegWriteE = 1; ResultSrcE = 2'b10; RDE = 5'd31; PCPlus4E = 32'h204;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("pass_rd", {27'd0, RDM}, 32'd31);
            chk("pass_pc4", PCPlus4M, 32'h204);
            chk("pass_rs", {30'd0, ResultSrcM}, 32'd2);
        end

        // Randomized cycles with occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 15) != 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
